// File: rtl/sat_accumulator.sv
// Streaming signed accumulator: sums LEN operands wide, saturates to DATA_W, valid/ready out.
// Optional SAT_ACC_RELU_EN clamps negative sums to zero instead of saturating low.
module sat_accumulator #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic signed [ACC_W-1:0] MAX_POS =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
`ifndef SAT_ACC_RELU_EN
    localparam logic signed [ACC_W-1:0] MIN_NEG =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;
    logic                     beat;
    logic signed [ACC_W-1:0]  in_ext;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign beat      = in_valid & in_ready;
    assign in_ext    = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = len;
                    state_d = (len != '0) ? ACCUM : SAT;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = acc_q + in_ext;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) state_d = SAT;
                end
            end
            SAT: begin
                state_d = OUT;
                if (acc_q > MAX_POS) begin
                    out_data_d = {1'b0, {(DATA_W-1){1'b1}}};
                    out_sat_d  = 1'b1;
`ifdef SAT_ACC_RELU_EN
                end else if (acc_q < 0) begin
                    // Rectification to zero is the intended function, not an overflow.
                    out_data_d = '0;
                    out_sat_d  = 1'b0;
`else
                end else if (acc_q < MIN_NEG) begin
                    out_data_d = {1'b1, {(DATA_W-1){1'b0}}};
                    out_sat_d  = 1'b1;
`endif
                end else begin
                    out_data_d = acc_q[DATA_W-1:0];
                    out_sat_d  = 1'b0;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_sat_accumulator.sv
// Bench for sat_accumulator: directed cases plus random vectors against an integer-sum model.
module tb_sat_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] vec_q[$];

    sat_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer sum of the operands, then clamp to the 32-bit range.
    task automatic model(output logic [31:0] exp_d, output logic exp_s);
        longint s = 0;
        foreach (vec_q[i]) s += longint'($signed(vec_q[i]));
        if (s > 64'sd2147483647) begin
            exp_d = 32'h7FFF_FFFF; exp_s = 1'b1;
        end else if (s < -64'sd2147483648) begin
`ifdef SAT_ACC_RELU_EN
            exp_d = 32'h0; exp_s = 1'b0;
`else
            exp_d = 32'h8000_0000; exp_s = 1'b1;
`endif
`ifdef SAT_ACC_RELU_EN
        end else if (s < 0) begin
            exp_d = 32'h0; exp_s = 1'b0;
`endif
        end else begin
            exp_d = s[31:0]; exp_s = 1'b0;
        end
    endtask

    task automatic run_vec(input bit gaps, input int hold);
        logic [31:0] exp_d;
        logic        exp_s;
        model(exp_d, exp_s);
        start = 1'b1;
        len   = 8'(vec_q.size());
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        foreach (vec_q[i]) begin
            while (gaps && ($urandom % 3 == 0)) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                chk("in_ready_gap", in_ready, 1);
                tick();
            end
            in_valid = 1'b1;
            in_data  = vec_q[i];
            chk("in_ready_beat", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        chk("sat_cycle_no_valid", out_valid, 0);
        chk("sat_cycle_in_ready", in_ready, 0);
        tick();
        chk("out_valid_latency", out_valid, 1);
        chk("out_data", out_data, exp_d);
        chk("out_sat", out_sat, exp_s);
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            len   = 8'($urandom_range(0, 5));
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, exp_d);
            chk("hold_sat", out_sat, exp_s);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd3;
        tick();
        chk("accept_valid_drop", out_valid, 0);
        chk("accept_start_ignored", busy, 0);
        out_ready = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_no_start", busy, 0);

        vec_q = '{32'd5, 32'hFFFF_FFFE, 32'd10};
        run_vec(1'b0, 0);
        vec_q = '{32'h7FFF_FFFF, 32'd1};
        run_vec(1'b0, 0);
        vec_q = '{32'h8000_0000, 32'hFFFF_FFFF};
        run_vec(1'b0, 0);
        vec_q = '{32'd100, 32'hFFFF_FF00, 32'd7, 32'd1000};
        run_vec(1'b1, 5);
        vec_q = {};
        run_vec(1'b0, 0);

        // Reset in the middle of a vector discards it without output.
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd11; tick();
        in_data = 32'd22; tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_sat", out_sat, 0);
        tick();
        rst = 1'b0;
        tick();
        vec_q = '{32'd7};
        run_vec(1'b0, 0);

        vec_q = {};
        for (int i = 0; i < 255; i++) vec_q.push_back(32'h8000_0000);
        run_vec(1'b0, 0);
        vec_q = {};
        for (int i = 0; i < 255; i++) vec_q.push_back(32'h7FFF_FFFF);
        run_vec(1'b1, 1);

        for (int v = 0; v < 40; v++) begin
            int n;
            vec_q = {};
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                case ($urandom % 4)
                    0: vec_q.push_back(32'h7FFF_FFFF - $urandom_range(0, 3));
                    1: vec_q.push_back(32'h8000_0000 + $urandom_range(0, 3));
                    2: vec_q.push_back(32'($signed($urandom_range(0, 2000)) - 1000));
                    default: vec_q.push_back($urandom);
                endcase
            end
            run_vec(1'($urandom % 2), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
